ecg_sample_delay: RTL and testbench
===================================

# ecg_sample_delay

AXI-Stream sample delay line that phase-aligns the ECG processing branches before QRS detection. One instance sits on the FIR bandpass output (DELAY=350) and one on the 75-point moving-average output (DELAY=43). Together they line up both signals with the smoothed 2nd-derivative branch, sample for sample. Delay is counted in accepted input beats (tvalid pulses), not clock cycles, so it is independent of sample rate.

## Interface
- DATA_W, 32: sample width, signed two's complement.
- DELAY, 350: delay in samples; legal range 0..1023.
- sys_clock  in  1  system clock (12 MHz nominal).
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear pulse; restarts priming.
- s_axis_tdata  in  DATA_W  input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_W  delayed sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- primed  out  1  high once DELAY samples have been stored; delayed data is genuine.

## Operation
- Circular buffer of DELAY entries, write/read pointer `ptr` in 0..DELAY-1, plus fill counter `cnt` in 0..DELAY (saturating).
- The block accepts an input when s_axis_tvalid && s_axis_tready. On accept:
  - Read `old = mem[ptr]`.
  - Write `mem[ptr] = s_axis_tdata`.
  - Advance `ptr` to `(ptr == DELAY-1) ? 0 : ptr+1`.
  - Increment `cnt` while `cnt < DELAY`.
- States:
  - PRIME (`cnt < DELAY`). Accepted beats are handled per the configuration macro.
  - RUN (`cnt == DELAY`). Each accepted beat loads `old` into the output register. Output sample n equals input sample n-DELAY.
- PRIME→RUN on the accept that makes `cnt == DELAY`. That beat is itself still a priming beat.
- RUN→PRIME only on reset or flush.
- DELAY=0: always RUN, no memory; behaves as a one-stage register slice. primed=1 out of reset.
- Data passes bit-exact; no arithmetic, no width change.
- Memory is not cleared on reset or flush. `cnt` guarantees stale contents never reach the output.

## Timing
- Reset values: s_axis_tready=0 while reset asserted; m_axis_tvalid=0, m_axis_tdata=0, primed=0 (1 if DELAY=0), ptr=0, cnt=0, state PRIME.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, gated by reset released.
- Latency: an input accepted at edge k produces m_axis_tvalid=1 with the corresponding data after edge k (visible in cycle k+1).
- m_axis_tvalid/m_axis_tdata hold stable until m_axis_tready=1. Simultaneous output handshake and new input accept at the same edge: the output register reloads with no bubble. Sustains one beat per clock.
- m_axis_tready low with a full output register: s_axis_tready=0, so no input is lost.
- primed rises on the edge of the DELAY-th accept.
- flush at an edge:
  - Clears ptr, cnt, m_axis_tvalid and primed.
  - Any input presented that cycle is dropped.
  - flush has priority over the handshake.
- Reset asserted mid-stream: immediate return to reset values, regardless of clock.

## Configuration
- PHASE_ALIGN_PRIME_ZERO_EN defined: every priming accept emits an output beat with tdata=0. Output beat count equals input beat count, which preserves sample indexing across branches.
- Undefined: priming accepts emit no output beat. The first output beat is input sample 0, emitted on the accept of input sample DELAY. Output count is input count minus DELAY.
- RUN-state behaviour is identical in both builds.

## Test plan
- DELAY=4, ramp input 1,2,3,… with m_axis_tready=1:
  - With PRIME_ZERO_EN: outputs 0,0,0,0,1,2,3…
  - Without: first output is 1, produced on the accept of input 5.
  - primed rises after the 4th accept.
- DELAY=350, 2000 ECG file samples at one beat per 12 clocks: output[n] == input[n-350] for all n ≥ 350; primed after input 350.
- Backpressure with DELAY=4: hold m_axis_tready=0 for 10 cycles mid-stream.
  - s_axis_tready drops one cycle after the output fills.
  - Output data is held stable.
  - No sample is lost or duplicated after release.
- Back-to-back streaming, tvalid=tready=1 continuously for 100 beats: one output per clock, sequence intact across pointer wrap at ptr=DELAY-1.
- flush after 200 samples (DELAY=43): primed=0, next 43 outputs are zero (PRIME_ZERO_EN), then the post-flush input 0 appears. No pre-flush data leaks.
- Async reset asserted between clock edges mid-stream: m_axis_tvalid=0 immediately. After release, behaviour matches a fresh start. DELAY=0: output equals input with one-cycle latency.

Source files
------------

// File: rtl/ecg_sample_delay.sv
// AXI-Stream sample delay line that phase-aligns ECG branches; delay is counted in accepted beats.
// Build option: define PHASE_ALIGN_PRIME_ZERO_EN to emit zero-valued beats while priming.
module ecg_sample_delay #(
  parameter int DATA_W = 32,
  parameter int DELAY  = 350
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              primed
);

  localparam int PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  // A zero-length line never primes: it starts and stays in RUN as a plain register slice.
  localparam state_t RESET_STATE = (DELAY == 0) ? RUN : PRIME;
  localparam logic   RESET_PRIMED = (DELAY == 0);

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  old_data;
  logic               accept;

  assign s_axis_tready = reset && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready && !flush;

  generate
    if (DELAY == 0) begin : g_nomem
      assign old_data = s_axis_tdata;
    end else begin : g_mem
      logic [DATA_W-1:0] mem [DELAY];

      // Read-before-write on the same slot: old_data is the sample stored DELAY accepts ago.
      always_ff @(posedge sys_clock) begin
        if (accept) begin
          mem[ptr_q] <= s_axis_tdata;
        end
      end

      assign old_data = mem[ptr_q];
    end
  endgenerate

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RESET_STATE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      primed        <= RESET_PRIMED;
    end else if (flush) begin
      state_q       <= RESET_STATE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      m_axis_tvalid <= 1'b0;
      primed        <= RESET_PRIMED;
    end else if (accept) begin
      ptr_q <= (ptr_q == PTR_W'(DELAY - 1)) ? '0 : ptr_q + PTR_W'(1);
      case (state_q)
        PRIME: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DELAY - 1)) begin
            state_q <= RUN;
            primed  <= 1'b1;
          end
`ifdef PHASE_ALIGN_PRIME_ZERO_EN
          m_axis_tdata  <= '0;
          m_axis_tvalid <= 1'b1;
`else
          m_axis_tvalid <= m_axis_tvalid && !m_axis_tready;
`endif
        end
        RUN: begin
          m_axis_tdata  <= old_data;
          m_axis_tvalid <= 1'b1;
        end
        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ecg_sample_delay.sv
// Self-checking bench for ecg_sample_delay: DELAY=4 line against a queue model, plus a DELAY=0 slice.
module tb_ecg_sample_delay;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] s_tdata;
  logic        s_valid;
  logic        s_tready, s_tready0;
  logic [31:0] m_tdata, m_tdata0;
  logic        m_tvalid, m_tvalid0;
  logic        m_ready;
  logic        m_ready0 = 1'b1;
  logic        primed, primed0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] hist[$];
  logic [31:0] expq[$];
  int          n_acc;

  always #5 clk = ~clk;

  ecg_sample_delay #(.DATA_W(32), .DELAY(D)) dut (
    .sys_clock(clk), .reset(reset), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_valid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_ready),
    .primed(primed)
  );

  ecg_sample_delay #(.DATA_W(32), .DELAY(0)) dut0 (
    .sys_clock(clk), .reset(reset), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_valid), .s_axis_tready(s_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_ready0),
    .primed(primed0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    expq.delete();
    n_acc = 0;
  endtask

  // One clock: sample handshakes before the edge, update the model, check state after it.
  task automatic step();
    logic        acc, ohs, acc0, held;
    logic [31:0] od, din;
    #1;
    chk("s_tready", s_tready, (expq.size() == 0) || m_ready);
    chk("s_tready0", s_tready0, 1'b1);
    acc  = s_valid && s_tready && !flush;
    ohs  = m_tvalid && m_ready;
    held = m_tvalid && !m_ready;
    acc0 = s_valid && !flush;
    od   = m_tdata;
    din  = s_tdata;
    @(posedge clk);
    #1;
    if (flush) begin
      model_clear();
    end else begin
      if (held) chk("m_hold", m_tdata, od);
      if (ohs) begin
        chk("beat_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) chk("m_tdata", od, expq.pop_front());
      end
      if (acc) begin
        hist.push_back(din);
        if (n_acc >= D) expq.push_back(hist[n_acc-D]);
`ifdef PHASE_ALIGN_PRIME_ZERO_EN
        else expq.push_back(32'd0);
`endif
        n_acc++;
      end
    end
    chk("primed", primed, n_acc >= D);
    chk("m_tvalid", m_tvalid, expq.size() != 0);
    chk("m_tvalid0", m_tvalid0, acc0);
    if (acc0) chk("m_tdata0", m_tdata0, din);
  endtask

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_tdata = '0;
    m_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_primed", primed, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid0", m_tvalid0, 1'b0);
    chk("rst_primed0", primed0, 1'b1);
    chk("rst_s_tready0", s_tready0, 1'b0);
    reset = 1'b1;

    // Back-to-back ramp 1,2,3,... across several pointer wraps.
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      s_tdata = i;
      step();
    end

    // Downstream stall mid-stream, then release.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 100 + i;
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 200 + i;
      step();
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      s_tdata = $urandom;
      step();
    end

    // Flush drops the presented beat and restarts priming.
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_tdata = 32'hdead_beef;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 300 + i;
      step();
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      s_tdata = 400 + i;
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_m_tvalid", m_tvalid, 1'b0);
    chk("arst_m_tdata", m_tdata, 32'd0);
    chk("arst_primed", primed, 1'b0);
    chk("arst_s_tready", s_tready, 1'b0);
    chk("arst_m_tvalid0", m_tvalid0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 40; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_tdata = $urandom;
      step();
    end

    // Drain.
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
